// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO and its read-side stream adapter.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH       = 8;
  localparam int unsigned STREAM_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order data store: captures go to the tail, pops take the head.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output occ_t                  occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  occ_t                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (cap_i) begin
          head_d = cap_data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (cap_i && pop_i) begin
          head_d = cap_data_i;
        end else if (cap_i) begin
          tail_d = cap_data_i;
          occ_d  = OCC_TWO;
        end else if (pop_i) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // The issue rule never lets a capture land while full.
        if (pop_i) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    if (flush_i) begin
      occ_d = OCC_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for fifo_async: hides the 1-cycle read latency behind a
// 2-entry prefetch buffer and presents a full-throughput valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  occ_t                 occ;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;
  logic                 pop;
  logic                 cap;
  logic [2:0]           fill;

  assign m_valid = (occ != OCC_EMPTY);
  assign pop     = m_valid && m_ready;
  // A word landing during flush is discarded rather than buffered.
  assign cap     = inflight_q && !flush;
  assign fill    = {1'b0, 2'(occ)} + {2'b00, inflight_q};

  always_comb begin
    // Gated by reset so the pop request drops the instant reset asserts.
    fifo_rd_en   = rd_rst_n && !fifo_empty && !flush && (fill < (3'd2 + {2'b00, pop}));
    inflight_d   = fifo_rd_en;
    xfer_count_d = xfer_count_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q   <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf (
    .clk_i     (rd_clk),
    .rst_ni    (rd_rst_n),
    .flush_i   (flush),
    .cap_i     (cap),
    .cap_data_i(fifo_rd_data),
    .pop_i     (pop),
    .occ_o     (occ),
    .head_o    (m_data)
  );

  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed checks of fifo_rd_stream against a behavioural fifo_async read port.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] xfer_count;

  int total = 0;
  int bad   = 0;

  // FIFO model: wr_ptr owned by the stimulus, rd_ptr by the read port.
  logic [DW-1:0] mem [0:69999];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            cyc_cnt = 0;

  logic [DW-1:0] rx [$];
  int            rx_cyc [$];
  int            rden_cnt = 0;
  int            valid_cnt = 0;
  int            contract_viol = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .xfer_count  (xfer_count)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(negedge rd_clk) begin
    if (rd_rst_n) begin
      if (m_valid && m_ready) begin
        rx.push_back(m_data);
        rx_cyc.push_back(cyc_cnt);
      end
      if (fifo_rd_en) rden_cnt++;
      if (m_valid) valid_cnt++;
      if (fifo_rd_en && fifo_empty) contract_viol++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic do_reset;
    rd_rst_n = 1'b0;
    flush    = 1'b0;
    m_ready  = 1'b0;
    wr_ptr   = rd_ptr;
    cyc(2);
    rd_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rd_rst_n = 1'b0;
    push(8'h5A);
    cyc(2);
    @(negedge rd_clk);
    total++;
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    total++;
    if (m_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=00", m_data); end
    total++;
    if (xfer_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", xfer_count); end
    cyc(1);
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    total++;
    if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL first_issue got=%b want=1", fifo_rd_en); end
    cyc(2);
    @(negedge rd_clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
      bad++;
      $display("FAIL first_word got=%b/%h want=1/5a", m_valid, m_data);
    end
    cyc(1);
  endtask

  task automatic test_stream;
    int rb;
    do_reset();
    rb = rx.size();
    m_ready = 1'b1;
    push(8'hA1); push(8'hB2); push(8'hC3);
    cyc(10);
    total++;
    if (rx.size() - rb != 3) begin
      bad++; $display("FAIL stream_count got=%0d want=3", rx.size() - rb);
    end else begin
      total++;
      if (rx[rb] !== 8'hA1 || rx[rb+1] !== 8'hB2 || rx[rb+2] !== 8'hC3) begin
        bad++; $display("FAIL stream_data got=%h %h %h want=a1 b2 c3", rx[rb], rx[rb+1], rx[rb+2]);
      end
      total++;
      if (rx_cyc[rb+1] != rx_cyc[rb] + 1 || rx_cyc[rb+2] != rx_cyc[rb] + 2) begin
        bad++;
        $display("FAIL stream_rate got=%0d %0d %0d want=consecutive",
                 rx_cyc[rb], rx_cyc[rb+1], rx_cyc[rb+2]);
      end
    end
    total++;
    if (xfer_count !== 16'd3) begin bad++; $display("FAIL stream_xfer got=%0d want=3", xfer_count); end
  endtask

  task automatic test_backpressure;
    int rb;
    int rdb;
    int changed;
    logic [DW-1:0] exp_w [4];
    exp_w[0] = 8'hA1; exp_w[1] = 8'hB2; exp_w[2] = 8'hC3; exp_w[3] = 8'hD4;
    do_reset();
    changed = 0;
    rdb = rden_cnt;
    for (int i = 0; i < 4; i++) push(exp_w[i]);
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (m_valid && m_data !== 8'hA1) changed++;
      cyc(1);
    end
    total++;
    if (rden_cnt - rdb != 2) begin bad++; $display("FAIL bp_rd_en got=%0d want=2", rden_cnt - rdb); end
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'hA1 || changed != 0) begin
      bad++; $display("FAIL bp_hold got=%b/%h/%0d want=1/a1/0", m_valid, m_data, changed);
    end
    rb = rx.size();
    m_ready = 1'b1;
    for (int i = 0; i < 20 && (rx.size() - rb < 4); i++) cyc(1);
    total++;
    if (rx.size() - rb != 4) begin
      bad++; $display("FAIL bp_release got=%0d want=4", rx.size() - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rx[rb+i] !== exp_w[i]) begin
          bad++; $display("FAIL bp_order[%0d] got=%h want=%h", i, rx[rb+i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_empty;
    int rdb;
    int vb;
    do_reset();
    m_ready = 1'b1;
    rdb = rden_cnt;
    vb  = valid_cnt;
    cyc(20);
    total++;
    if (rden_cnt != rdb) begin bad++; $display("FAIL empty_rd_en got=%0d want=0", rden_cnt - rdb); end
    total++;
    if (valid_cnt != vb) begin bad++; $display("FAIL empty_valid got=%0d want=0", valid_cnt - vb); end
  endtask

  task automatic test_flush;
    int rb;
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    cyc(2);
    flush = 1'b1;
    @(negedge rd_clk);
    total++;
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL flush_rd_en got=%b want=0", fifo_rd_en); end
    cyc(1);
    flush   = 1'b0;
    m_ready = 1'b1;
    rb = rx.size();
    @(negedge rd_clk);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", m_valid); end
    cyc(6);
    total++;
    if (rx.size() - rb != 1 || rx[rb] !== 8'h33) begin
      bad++; $display("FAIL flush_next got=%0d words first=%h want=1 words 33", rx.size() - rb, rx[rb]);
    end
    total++;
    if (xfer_count !== 16'd1) begin bad++; $display("FAIL flush_xfer got=%0d want=1", xfer_count); end
  endtask

  task automatic test_toggle;
    int rb;
    logic [DW-1:0] w;
    do_reset();
    rb = rx.size();
    for (int i = 0; i < 20; i++) push(DW'(i * 13 + 5));
    for (int i = 0; i < 100 && (rx.size() - rb < 20); i++) begin
      m_ready = (i % 2 == 0);
      cyc(1);
    end
    m_ready = 1'b0;
    cyc(3);
    total++;
    if (rx.size() - rb != 20) begin
      bad++; $display("FAIL toggle_count got=%0d want=20", rx.size() - rb);
    end else begin
      for (int i = 0; i < 20; i++) begin
        w = DW'(i * 13 + 5);
        total++;
        if (rx[rb+i] !== w) begin bad++; $display("FAIL toggle[%0d] got=%h want=%h", i, rx[rb+i], w); end
      end
    end
    total++;
    if (xfer_count !== 16'd20) begin bad++; $display("FAIL toggle_xfer got=%0d want=20", xfer_count); end
  endtask

  task automatic test_wrap;
    logic [CW-1:0] exp_c [3];
    exp_c[0] = 16'd65535; exp_c[1] = 16'd0; exp_c[2] = 16'd1;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 65534; i++) push(DW'(i));
    for (int i = 0; i < 70000 && xfer_count !== 16'd65534; i++) cyc(1);
    total++;
    if (xfer_count !== 16'd65534) begin
      bad++; $display("FAIL wrap_preload got=%0d want=65534", xfer_count);
    end
    m_ready = 1'b0;
    push(8'hE1); push(8'hE2); push(8'hE3);
    cyc(5);
    for (int k = 0; k < 3; k++) begin
      m_ready = 1'b1;
      @(negedge rd_clk);
      total++;
      if (m_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d] got=%b want=1", k, m_valid); end
      cyc(1);
      m_ready = 1'b0;
      @(negedge rd_clk);
      total++;
      if (xfer_count !== exp_c[k]) begin
        bad++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", k, xfer_count, exp_c[k]);
      end
      cyc(1);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(8'h40 + i));
    cyc(2);
    @(negedge rd_clk);
    total++;
    if (fifo_rd_en !== 1'b1 || m_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b/%b want=1/1", fifo_rd_en, m_valid);
    end
    rd_rst_n = 1'b0;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_clear got=%b/%b want=0/0", fifo_rd_en, m_valid);
    end
    cyc(1);
  endtask

  task automatic test_contract;
    total++;
    if (contract_viol != 0) begin
      bad++; $display("FAIL rd_en_while_empty got=%0d want=0", contract_viol);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_flush();
    test_toggle();
    test_reset_mid();
    test_wrap();
    test_contract();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
